// File: rtl/arm_pkg.sv
// Shared A64 writeback types: result request struct, load size encoding, extension helpers.
// Pure declarations; no timing or flow control lives here.
package arm_pkg;

  localparam int XLEN = 64;
  localparam logic [4:0] REG_XZR_SP = 5'd31;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_e;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            is32;
    logic            wr_sp;
  } wb_req_t;

  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d, input mem_size_e sz,
                                               input logic sgn, input logic is32);
    logic [XLEN-1:0] r;
    case (sz)
      SZ_B:    r = {{(XLEN-8){sgn & d[7]}}, d[7:0]};
      SZ_H:    r = {{(XLEN-16){sgn & d[15]}}, d[15:0]};
      SZ_W:    r = {{(XLEN-32){sgn & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    if (is32) r[XLEN-1:32] = '0;
    return r;
  endfunction

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    return 32'd1 << rd;
  endfunction

  // rd 31 from the execute side is the zero register unless the op targets SP.
  function automatic logic is_xzr_drop(input wb_req_t r);
    return (r.rd == REG_XZR_SP) && !r.wr_sp;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Execute, load-response and register-file write-port bundle around the writeback stage.
// ex_* is valid/ready; mem_* has no backpressure; the write port is a registered output.
interface wb_stage_if;
  import arm_pkg::*;

  logic            ex_valid;
  logic            ex_ready;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_data;
  logic            ex_is32;
  logic            ex_wr_sp;

  logic            mem_valid;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  mem_size_e       mem_size;
  logic            mem_signed;
  logic            mem_is32;

  logic            RegWrite;
  logic [4:0]      Write_register;
  logic [XLEN-1:0] Write_d;
  logic [31:0]     wb_pending;

  modport master (
    output ex_valid, ex_rd, ex_data, ex_is32, ex_wr_sp,
    output mem_valid, mem_rd, mem_data, mem_size, mem_signed, mem_is32,
    input  ex_ready, RegWrite, Write_register, Write_d, wb_pending
  );

  modport slave (
    input  ex_valid, ex_rd, ex_data, ex_is32, ex_wr_sp,
    input  mem_valid, mem_rd, mem_data, mem_size, mem_signed, mem_is32,
    output ex_ready, RegWrite, Write_register, Write_d, wb_pending
  );

endinterface

// File: rtl/wb_fifo.sv
// Execute-result buffer with registered full/empty; head is combinational from the read pointer.
// Push and pop may coincide, including a push into a full FIFO that is popping the same cycle.
module wb_fifo
  import arm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  wb_req_t     push_dat,
  input  logic        pop,
  output wb_req_t     head,
  output logic        full,
  output logic        empty,
  output logic [31:0] pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t          slots [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;

  assign cnt_nxt = cnt + CW'(push) - CW'(pop);
  assign head    = slots[rd_ptr];

  // Clear-on-pop precedes set-on-push so a full FIFO pushing while popping keeps the slot live.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == CW'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_dat;
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && !is_xzr_drop(slots[i])) pending = pending | rd_onehot(slots[i].rd);
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Merges load responses (priority) and buffered execute results onto the register-file write port; one registered cycle, empty buffer is flow-through.
// ex_ready is the registered not-full flag; loads never stall and simply make queued execute results wait.
module wb_stage #(
  parameter int XLEN       = arm_pkg::XLEN,
  parameter int FIFO_DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  wb_stage_if.slave wb
);
  import arm_pkg::*;

  wb_req_t         ex_req;
  wb_req_t         head;
  wb_req_t         sel;
  logic            accept;
  logic            pop;
  logic            bypass;
  logic            push;
  logic            full;
  logic            empty;
  logic [31:0]     fifo_pend;
  logic            reg_write;
  logic [4:0]      wr_reg;
  logic [XLEN-1:0] wr_d;
  logic [XLEN-1:0] sel_d;

  assign accept = wb.ex_valid && wb.ex_ready;
  assign ex_req = '{rd: wb.ex_rd, data: wb.ex_data, is32: wb.ex_is32, wr_sp: wb.ex_wr_sp};

  // A beat arriving at an empty, unblocked buffer goes straight to the output register.
  assign pop    = !wb.mem_valid && !empty;
  assign bypass = !wb.mem_valid && empty && accept;
  assign push   = accept && !bypass;

  assign sel   = pop ? head : ex_req;
  assign sel_d = sel.is32 ? {{(XLEN-32){1'b0}}, sel.data[31:0]} : sel.data;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (ex_req),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .pending  (fifo_pend)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write <= 1'b0;
      wr_reg    <= '0;
      wr_d      <= '0;
    end else if (wb.mem_valid) begin
      reg_write <= (wb.mem_rd != REG_XZR_SP);
      wr_reg    <= wb.mem_rd;
      wr_d      <= load_ext(wb.mem_data, wb.mem_size, wb.mem_signed, wb.mem_is32);
    end else if (pop || bypass) begin
      reg_write <= !is_xzr_drop(sel);
      wr_reg    <= sel.rd;
      wr_d      <= sel_d;
    end else begin
      reg_write <= 1'b0;
    end
  end

  assign wb.ex_ready       = !full;
  assign wb.RegWrite       = reg_write;
  assign wb.Write_register = wr_reg;
  assign wb.Write_d        = wr_d;
  assign wb.wb_pending     = fifo_pend | (reg_write ? rd_onehot(wr_reg) : 32'd0);

endmodule

// File: tb/tb_wb_stage.sv
// Directed and randomized bench for wb_stage against a queue-level writeback model.
module tb_wb_stage;
  import arm_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wb_stage_if bif();

  wb_stage #(.XLEN(64), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bif)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] d;
    logic        sp;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [63:0] m_d;
  logic        m_ready;
  int          n_assert = 0;
  int          n_fail = 0;
  ent_t        seen[$];

  function automatic logic [63:0] ref_load(input logic [63:0] d, input int sz, input logic sgn,
                                           input logic is32);
    logic [63:0] mask;
    logic [63:0] v;
    int          bits;
    if (sz == 3) begin
      v = d;
    end else begin
      bits = 8 << sz;
      mask = (64'd1 << bits) - 64'd1;
      v = d & mask;
      if (sgn && d[bits-1]) v = v | ~mask;
    end
    if (is32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] p;
    p = '0;
    foreach (q[i]) if (!(q[i].rd == 5'd31 && !q[i].sp)) p[q[i].rd] = 1'b1;
    if (m_we) p[m_rd] = 1'b1;
    return p;
  endfunction

  task automatic model_clear();
    q.delete();
    m_we = 1'b0;
    m_rd = '0;
    m_d = '0;
    m_ready = 1'b1;
  endtask

  task automatic model_edge();
    ent_t e;
    ent_t h;
    logic acc;
    if (!reset) begin
      model_clear();
      return;
    end
    acc  = bif.ex_valid && m_ready;
    e.rd = bif.ex_rd;
    e.d  = bif.ex_is32 ? {32'd0, bif.ex_data[31:0]} : bif.ex_data;
    e.sp = bif.ex_wr_sp;
    if (acc) q.push_back(e);
    if (bif.mem_valid) begin
      m_we = (bif.mem_rd != 5'd31);
      m_rd = bif.mem_rd;
      m_d  = ref_load(bif.mem_data, int'(bif.mem_size), bif.mem_signed, bif.mem_is32);
    end else if (q.size() > 0) begin
      h    = q.pop_front();
      m_we = !(h.rd == 5'd31 && !h.sp);
      m_rd = h.rd;
      m_d  = h.d;
    end else begin
      m_we = 1'b0;
    end
    m_ready = (q.size() < 2);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    check("ex_ready", 64'(bif.ex_ready), 64'(m_ready));
    check("RegWrite", 64'(bif.RegWrite), 64'(m_we));
    if (m_we) begin
      check("Write_register", 64'(bif.Write_register), 64'(m_rd));
      check("Write_d", bif.Write_d, m_d);
    end
    check("wb_pending", 64'(bif.wb_pending), 64'(m_pend()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    if (bif.RegWrite) seen.push_back('{rd: bif.Write_register, d: bif.Write_d, sp: 1'b0});
  endtask

  task automatic drive_ex(input logic v, input logic [4:0] rd, input logic [63:0] d,
                          input logic is32, input logic sp);
    bif.ex_valid = v;
    bif.ex_rd    = rd;
    bif.ex_data  = d;
    bif.ex_is32  = is32;
    bif.ex_wr_sp = sp;
  endtask

  task automatic drive_mem(input logic v, input logic [4:0] rd, input logic [63:0] d,
                           input logic [1:0] sz, input logic sgn, input logic is32);
    bif.mem_valid  = v;
    bif.mem_rd     = rd;
    bif.mem_data   = d;
    bif.mem_size   = mem_size_e'(sz);
    bif.mem_signed = sgn;
    bif.mem_is32   = is32;
  endtask

  task automatic idle();
    drive_ex(1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    drive_mem(1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_RegWrite"}, 64'(bif.RegWrite), 64'd0);
    check({tag, "_Write_register"}, 64'(bif.Write_register), 64'd0);
    check({tag, "_Write_d"}, bif.Write_d, 64'd0);
    check({tag, "_ex_ready"}, 64'(bif.ex_ready), 64'd1);
    check({tag, "_wb_pending"}, 64'(bif.wb_pending), 64'd0);
  endtask

  initial begin
    int sent;
    logic [63:0] rnd;

    idle();
    model_clear();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // Single execute beat: visible the cycle after acceptance, pending only while in the output stage.
    drive_ex(1'b1, 5'd5, 64'h1122334455667788, 1'b0, 1'b0);
    tick();
    check("single_we", 64'(bif.RegWrite), 64'd1);
    check("single_rd", 64'(bif.Write_register), 64'd5);
    check("single_d", bif.Write_d, 64'h1122334455667788);
    check("single_pend5", 64'(bif.wb_pending[5]), 64'd1);
    idle();
    tick();
    check("single_pend_clear", 64'(bif.wb_pending), 64'd0);

    // Byte loads: signed, signed W-form, unsigned.
    drive_mem(1'b1, 5'd3, 64'h80, 2'd0, 1'b1, 1'b0);
    tick();
    check("ld_sb", bif.Write_d, 64'hFFFF_FFFF_FFFF_FF80);
    drive_mem(1'b1, 5'd3, 64'h80, 2'd0, 1'b1, 1'b1);
    tick();
    check("ld_sb_w", bif.Write_d, 64'h0000_0000_FFFF_FF80);
    drive_mem(1'b1, 5'd3, 64'h80, 2'd0, 1'b0, 1'b0);
    tick();
    check("ld_ub", bif.Write_d, 64'h80);
    idle();
    tick();

    // Loads hold the port for three cycles while execute streams rd 1..3.
    seen.delete();
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      drive_mem(c < 3, 5'(10 + c), {$urandom, $urandom}, 2'd3, 1'b0, 1'b0);
      if (sent < 3) drive_ex(1'b1, 5'(sent + 1), 64'hA0 + 64'(sent), 1'b0, 1'b0);
      else drive_ex(1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
      if (c == 2) check("ready_low_when_full", 64'(bif.ex_ready), 64'd0);
      if (bif.ex_ready && sent < 3) begin
        tick();
        sent++;
      end else begin
        tick();
      end
    end
    check("order_count", 64'(seen.size()), 64'd6);
    if (seen.size() == 6) begin
      for (int i = 0; i < 3; i++) begin
        check("order_mem_rd", 64'(seen[i].rd), 64'(10 + i));
        check("order_ex_rd", 64'(seen[i+3].rd), 64'(i + 1));
        check("order_ex_d", seen[i+3].d, 64'hA0 + 64'(i));
      end
    end
    idle();
    tick();

    // Zero register versus stack pointer.
    drive_ex(1'b1, 5'd31, 64'hDEAD, 1'b0, 1'b0);
    tick();
    check("xzr_we", 64'(bif.RegWrite), 64'd0);
    check("xzr_pend", 64'(bif.wb_pending), 64'd0);
    drive_ex(1'b1, 5'd31, 64'h1000, 1'b0, 1'b1);
    tick();
    check("sp_we", 64'(bif.RegWrite), 64'd1);
    check("sp_rd", 64'(bif.Write_register), 64'd31);
    check("sp_d", bif.Write_d, 64'h1000);
    drive_mem(1'b1, 5'd31, 64'h55, 2'd3, 1'b0, 1'b0);
    drive_ex(1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    check("mem_xzr_we", 64'(bif.RegWrite), 64'd0);
    idle();
    tick();

    // Reset mid-stream with two execute results queued behind loads.
    drive_mem(1'b1, 5'd20, 64'h1, 2'd3, 1'b0, 1'b0);
    drive_ex(1'b1, 5'd7, 64'h77, 1'b0, 1'b0);
    tick();
    drive_mem(1'b1, 5'd21, 64'h2, 2'd3, 1'b0, 1'b0);
    drive_ex(1'b1, 5'd8, 64'h88, 1'b0, 1'b0);
    tick();
    check("queued_two", 64'(q.size()), 64'd2);
    drive_ex(1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check_reset_outputs("midreset");
    idle();
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      tick();
      check("no_stale", 64'(bif.RegWrite), 64'd0);
    end

    // Back-to-back execute beats: full throughput, no backpressure.
    for (int i = 0; i < 20; i++) begin
      drive_ex(1'b1, 5'($urandom_range(0, 30)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
      tick();
      check("b2b_we", 64'(bif.RegWrite), 64'd1);
      check("b2b_ready", 64'(bif.ex_ready), 64'd1);
    end
    idle();
    tick();

    // Randomized mix of both channels.
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom, $urandom};
      drive_ex($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), rnd,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drive_mem($urandom_range(0, 9) < 3, 5'($urandom_range(0, 31)), {$urandom, $urandom},
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    idle();
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly upstream of the register file.
- Merges results from the execute channel (buffered, valid/ready) and the load-response channel (priority, no backpressure) onto the register file's single write port (RegWrite / Write_register / Write_d).
- Applies A64 result rules: W-form zero-extension, load sign/zero extension, XZR write suppression.
- Exports a pending-write mask so decode can stall on RAW hazards.

Parameters:
- XLEN, 64, datapath width; must match the register file.
- FIFO_DEPTH, 2, execute-result buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute result valid.
- ex_ready  out  1  buffer can accept; registered, equals not-full.
- ex_rd  in  5  destination register.
- ex_data  in  XLEN  result.
- ex_is32  in  1  W-form result; upper 32 bits are forced to 0.
- ex_wr_sp  in  1  rd==31 means SP, not XZR.
- mem_valid  in  1  load data returned; must be consumed this cycle.
- mem_rd  in  5  load destination.
- mem_data  in  XLEN  raw load data, right-aligned.
- mem_size  in  2  0=byte, 1=half, 2=word, 3=dword.
- mem_signed  in  1  sign-extend the loaded value.
- mem_is32  in  1  extend to 32 bits, then zero the upper 32.
- RegWrite  out  1  to the register file.
- Write_register  out  5  to the register file.
- Write_d  out  XLEN  to the register file.
- wb_pending  out  32  bit r set while any queued or output-stage write targets r.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FIFO emptied.
  - RegWrite=0, Write_register=0, Write_d=0.
  - ex_ready=1, wb_pending=0.
  - A reset mid-operation discards all queued results.
- Execute handshake:
  - A beat is accepted when ex_valid and ex_ready are both high at the edge; it is pushed to the FIFO tail.
  - ex_ready is registered; it drops in the cycle after the FIFO becomes full.
- Per-cycle selection:
  - If mem_valid: the mem result drives the output registers.
  - Otherwise, if the FIFO is non-empty: the FIFO head is popped and drives the output registers.
  - Otherwise: RegWrite=0.
  - Push and pop in the same cycle are allowed; a push into a full FIFO is allowed when a pop occurs in that same cycle.
- Latency:
  - Input sampled at edge N → RegWrite/Write_d valid in cycle N+1 → register file captures at edge N+2.
  - An execute beat that has to queue behind mem traffic waits one extra cycle per blocking mem beat.
- Zero-register rule:
  - rd==31 with ex_wr_sp=0 produces RegWrite=0 but still consumes its slot, preserving order.
  - mem_rd==31 is always XZR and is always dropped.
- Extension:
  - mem: size 0/1/2 sign- or zero-extend from bit 7/15/31 per mem_signed; size 3 passes through.
  - If mem_is32: extend to 32 bits, then zero bits 63:32.
  - ex: if ex_is32, zero bits 63:32.
- Ordering:
  - The FIFO preserves execute order.
  - No ordering is enforced between the mem and execute channels; upstream must not issue both to the same rd out of order.
- wb_pending:
  - OR of one-hot(rd) over valid FIFO entries and the output stage when RegWrite=1.
  - Dropped XZR writes do not set a bit.
  - Combinational from registered state.
- mem_valid while the FIFO is full is legal; the FIFO simply holds.

Decomposition:
- Shared package arm_pkg:
  - XLEN.
  - REG_XZR_SP=5'd31.
  - mem_size enum (SZ_B, SZ_H, SZ_W, SZ_D).
  - wb_req_t struct {rd, data, is32, wr_sp}.
- Sub-module wb_fifo: parameterised synchronous FIFO of wb_req_t with registered full/empty and a pending-mask output.
- Extension logic stays inline as a function in the package.

Test Plan:
- Single ex beat rd=5, data=0x1122334455667788, is32=0 → cycle N+1: RegWrite=1, Write_register=5, Write_d=0x1122334455667788; wb_pending[5] high during cycles N+1..N+1.
- Load mem_size=0, mem_signed=1, mem_data=0x80, rd=3 → Write_d=0xFFFFFFFFFFFFFF80; same with mem_is32=1 → 0x00000000FFFFFF80; mem_signed=0 → 0x80.
- mem_valid held 3 cycles while ex sends rd=1,2,3 → mem writes appear first; FIFO fills; ex_ready=0 after 2 accepts; ex writes rd 1,2,3 follow in order with no loss.
- ex rd=31, wr_sp=0 → RegWrite stays 0, wb_pending=0; rd=31, wr_sp=1, data=0x1000 → RegWrite=1, Write_register=31.
- Assert reset low mid-stream with 2 entries queued → all outputs immediately 0, ex_ready=1; after release no stale writes emerge.
- Back-to-back ex beats every cycle with no mem traffic → one write per cycle, ex_ready never deasserts, throughput 1/cycle.
